// File: rtl/dft_complex_mul_block_if.sv
// ============================================================================
//  Module   : dft_complex_mul_block_if
//  Purpose  : Operand/result bundle for the DFT complex multiplier block,
//             carrying the companion valid flag alongside the data.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dft_complex_mul_block_if #(
  parameter int DATA_A_W = 16,
  parameter int DATA_B_W = 16
);
  logic signed [DATA_A_W-1:0] data_a_re;
  logic signed [DATA_A_W-1:0] data_a_im;
  logic signed [DATA_B_W-1:0] data_b_re;
  logic signed [DATA_B_W-1:0] data_b_im;
  logic                       valid_in;
  logic signed [DATA_A_W-1:0] result_re;
  logic signed [DATA_A_W-1:0] result_im;
  logic                       valid_out;

  // Producer side: drives operands, observes products.
  modport master (
    output data_a_re, data_a_im, data_b_re, data_b_im, valid_in,
    input  result_re, result_im, valid_out
  );

  // Multiplier side.
  modport slave (
    input  data_a_re, data_a_im, data_b_re, data_b_im, valid_in,
    output result_re, result_im, valid_out
  );
endinterface

`default_nettype wire

// File: rtl/dft_complex_mul_block.sv
// ============================================================================
//  Module   : dft_complex_mul_block (with dft_complex_mul, dft_dline)
//  Purpose  : Pipelined signed fixed-point complex multiplier A*B where B is
//             a Q1.(DATA_B_W-1) twiddle, plus a single-bit delay line that
//             keeps a valid flag aligned with the product.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dft_complex_mul #(
  parameter int DATA_A_W        = 16,
  parameter int DATA_B_W        = 16,
  parameter int PIPELINE_STAGES = 2
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic signed [DATA_A_W-1:0] data_a_re,
  input  wire logic signed [DATA_A_W-1:0] data_a_im,
  input  wire logic signed [DATA_B_W-1:0] data_b_re,
  input  wire logic signed [DATA_B_W-1:0] data_b_im,
  output logic signed [DATA_A_W-1:0]      result_re,
  output logic signed [DATA_A_W-1:0]      result_im
);
  localparam int c_prod_w = DATA_A_W + DATA_B_W;
  localparam int c_sum_w  = c_prod_w + 1;
  localparam int c_lsb    = DATA_B_W - 1;
  localparam int c_last   = PIPELINE_STAGES - 1;

  logic signed [DATA_A_W-1:0] r_ar, r_ai;
  logic signed [DATA_B_W-1:0] r_br, r_bi;

  // Operands sign-extended to product width so every multiply is exact.
  logic signed [c_prod_w-1:0] w_ar_x, w_ai_x, w_br_x, w_bi_x;
  logic signed [c_prod_w-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;

  logic signed [c_prod_w-1:0] r_rr [PIPELINE_STAGES];
  logic signed [c_prod_w-1:0] r_ii [PIPELINE_STAGES];
  logic signed [c_prod_w-1:0] r_ri [PIPELINE_STAGES];
  logic signed [c_prod_w-1:0] r_ir [PIPELINE_STAGES];

  // One guard bit above the products so the sum/difference cannot overflow.
  logic signed [c_sum_w-1:0] w_rr_s, w_ii_s, w_ri_s, w_ir_s;
  logic signed [c_sum_w-1:0] r_re_full, r_im_full;

  // Bits dropped by the rescale: fraction bits below the binary point and the
  // two wrap-away bits at the top.
  logic w_unused;

  assign w_ar_x = {{DATA_B_W{r_ar[DATA_A_W-1]}}, r_ar};
  assign w_ai_x = {{DATA_B_W{r_ai[DATA_A_W-1]}}, r_ai};
  assign w_br_x = {{DATA_A_W{r_br[DATA_B_W-1]}}, r_br};
  assign w_bi_x = {{DATA_A_W{r_bi[DATA_B_W-1]}}, r_bi};

  assign w_p_rr = w_ar_x * w_br_x;
  assign w_p_ii = w_ai_x * w_bi_x;
  assign w_p_ri = w_ar_x * w_bi_x;
  assign w_p_ir = w_ai_x * w_br_x;

  assign w_rr_s = {r_rr[c_last][c_prod_w-1], r_rr[c_last]};
  assign w_ii_s = {r_ii[c_last][c_prod_w-1], r_ii[c_last]};
  assign w_ri_s = {r_ri[c_last][c_prod_w-1], r_ri[c_last]};
  assign w_ir_s = {r_ir[c_last][c_prod_w-1], r_ir[c_last]};

  assign w_unused = ^{r_re_full[c_sum_w-1:c_lsb+DATA_A_W], r_re_full[c_lsb-1:0],
                      r_im_full[c_sum_w-1:c_lsb+DATA_A_W], r_im_full[c_lsb-1:0]};

  // Input register: capture all four operands every cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ar <= '0;
      r_ai <= '0;
      r_br <= '0;
      r_bi <= '0;
    end else begin
      r_ar <= data_a_re;
      r_ai <= data_a_im;
      r_br <= data_b_re;
      r_bi <= data_b_im;
    end
  end

  // Product pipeline: first stage multiplies, later stages only delay.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PIPELINE_STAGES; i++) begin
        r_rr[i] <= '0;
        r_ii[i] <= '0;
        r_ri[i] <= '0;
        r_ir[i] <= '0;
      end
    end else begin
      r_rr[0] <= w_p_rr;
      r_ii[0] <= w_p_ii;
      r_ri[0] <= w_p_ri;
      r_ir[0] <= w_p_ir;
      for (int i = 1; i < PIPELINE_STAGES; i++) begin
        r_rr[i] <= r_rr[i-1];
        r_ii[i] <= r_ii[i-1];
        r_ri[i] <= r_ri[i-1];
        r_ir[i] <= r_ir[i-1];
      end
    end
  end

  // Sum stage: full-precision real and imaginary parts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_re_full <= '0;
      r_im_full <= '0;
    end else begin
      r_re_full <= w_rr_s - w_ii_s;
      r_im_full <= w_ri_s + w_ir_s;
    end
  end

  // Output stage: drop the Q1 fraction bits (floor) and wrap to sample width.
  always_ff @(posedge clk) begin
    if (!rst) begin
      result_re <= '0;
      result_im <= '0;
    end else begin
      result_re <= r_re_full[c_lsb +: DATA_A_W];
      result_im <= r_im_full[c_lsb +: DATA_A_W];
    end
  end
endmodule

module dft_dline #(
  parameter int STAGES_N = 1
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic din,
  output logic      dout
);
  logic [STAGES_N-1:0] r_sr;

  generate
    if (STAGES_N == 1) begin : g_single
      // Single flop delay.
      always_ff @(posedge clk) begin
        if (!rst) r_sr <= 1'b0;
        else      r_sr <= din;
      end
    end else begin : g_multi
      // Shift the flag one position per clock toward the output end.
      always_ff @(posedge clk) begin
        if (!rst) r_sr <= '0;
        else      r_sr <= {r_sr[STAGES_N-2:0], din};
      end
    end
  endgenerate

  assign dout = r_sr[STAGES_N-1];
endmodule

module dft_complex_mul_block #(
  parameter int DATA_A_W        = 16,
  parameter int DATA_B_W        = 16,
  parameter int PIPELINE_STAGES = 2
) (
  input  wire logic               clk,
  input  wire logic               rst,
  dft_complex_mul_block_if.slave  bus
);
  // Flag delay equals the full register depth of the multiplier so valid_out
  // is high exactly while the matching product is on the outputs.
  localparam int c_lat_stages = PIPELINE_STAGES + 3;

  dft_complex_mul #(
    .DATA_A_W        (DATA_A_W),
    .DATA_B_W        (DATA_B_W),
    .PIPELINE_STAGES (PIPELINE_STAGES)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .data_a_re (bus.data_a_re),
    .data_a_im (bus.data_a_im),
    .data_b_re (bus.data_b_re),
    .data_b_im (bus.data_b_im),
    .result_re (bus.result_re),
    .result_im (bus.result_im)
  );

  dft_dline #(
    .STAGES_N (c_lat_stages)
  ) u_valid_dline (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.valid_in),
    .dout (bus.valid_out)
  );
endmodule

`default_nettype wire

// File: tb/tb_dft_complex_mul_block.sv
// ============================================================================
//  Module   : tb_dft_complex_mul_block
//  Purpose  : Randomized self-checking bench for dft_complex_mul_block with an
//             arithmetic reference model and a due-cycle expectation queue.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dft_complex_mul_block;
  localparam int A_W = 16;
  localparam int B_W = 16;
  localparam int P   = 2;
  // Output appears after edge n+P+2 for operands sampled at edge n.
  localparam int LAT = P + 2;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    int          due;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t q[$];

  dft_complex_mul_block_if #(.DATA_A_W(A_W), .DATA_B_W(B_W)) bus ();

  dft_complex_mul_block #(
    .DATA_A_W        (A_W),
    .DATA_B_W        (B_W),
    .PIPELINE_STAGES (P)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, want);
    end
  endtask

  // Exact complex product, then floor-divide by 2^(B_W-1) and keep 16 bits.
  function automatic logic [31:0] ref_mul(input logic [15:0] ar, input logic [15:0] ai,
                                          input logic [15:0] br, input logic [15:0] bi);
    longint sar, sai, sbr, sbi, re, im;
    sar = longint'($signed(ar));
    sai = longint'($signed(ai));
    sbr = longint'($signed(br));
    sbi = longint'($signed(bi));
    re  = (sar * sbr - sai * sbi) >>> (B_W - 1);
    im  = (sar * sbi + sai * sbr) >>> (B_W - 1);
    return {re[15:0], im[15:0]};
  endfunction

  // One clock: apply inputs, let the edge happen, then check at the falling edge.
  task automatic step(input logic v, input logic rst_n,
                      input logic [15:0] ar, input logic [15:0] ai,
                      input logic [15:0] br, input logic [15:0] bi,
                      input logic use_x, input logic [15:0] xre, input logic [15:0] xim);
    exp_t        e;
    logic [31:0] m;
    logic        exp_v;
    bus.valid_in  = v;
    bus.data_a_re = ar;
    bus.data_a_im = ai;
    bus.data_b_re = br;
    bus.data_b_im = bi;
    rst           = rst_n;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      q.delete();
    end else if (v) begin
      m     = ref_mul(ar, ai, br, bi);
      e.re  = use_x ? xre : m[31:16];
      e.im  = use_x ? xim : m[15:0];
      e.due = cyc + LAT;
      q.push_back(e);
    end
    @(negedge clk);
    exp_v = (q.size() > 0) && (q[0].due == cyc);
    chk("valid_out", 32'(bus.valid_out), 32'(exp_v));
    if (exp_v) begin
      e = q.pop_front();
      chk("result_re", 32'($unsigned(bus.result_re)), 32'(e.re));
      chk("result_im", 32'($unsigned(bus.result_im)), 32'(e.im));
    end else begin
      chk("idle_re", 32'($unsigned(bus.result_re)), 32'h0);
      chk("idle_im", 32'($unsigned(bus.result_im)), 32'h0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic rand_op(input logic rst_n);
    step(1'b1, rst_n, 16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()),
         1'b0, 16'h0, 16'h0);
  endtask

  // Directed vectors with hand-derived results.
  task automatic directed(input logic [15:0] ar, input logic [15:0] ai,
                          input logic [15:0] br, input logic [15:0] bi,
                          input logic [15:0] xre, input logic [15:0] xim);
    step(1'b1, 1'b1, ar, ai, br, bi, 1'b1, xre, xim);
  endtask

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    bus.valid_in  = 1'b0;
    bus.data_a_re = '0;
    bus.data_a_im = '0;
    bus.data_b_re = '0;
    bus.data_b_im = '0;

    // Reset held for a few edges: everything reads zero.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
    idle(2);

    // Directed corner cases, back-to-back.
    directed(16'h4000, 16'h0000, 16'h4000, 16'h0000, 16'h2000, 16'h0000);
    directed(16'h0000, 16'h4000, 16'h0000, 16'h4000, 16'hE000, 16'h0000);
    directed(16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000);
    directed(16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001);
    directed(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h0000);
    idle(LAT + 2);

    // 64 back-to-back random operand sets.
    for (int i = 0; i < 64; i++) rand_op(1'b1);
    idle(LAT + 2);

    // Streaming with a single-edge reset in the middle.
    for (int i = 0; i < 12; i++) rand_op(1'b1);
    rand_op(1'b0);
    for (int i = 0; i < 20; i++) rand_op(1'b1);

    // A sparse stream with random gaps.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(1, 0) == 1) rand_op(1'b1);
      else idle(1);
    end
    idle(LAT + 3);

    chk("drain", 32'(q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
